mips_cpu_mem_arbiter: RTL
=========================

// Module: mips_cpu_mem_arbiter
// PURPOSE
//  Shares one single-ported, wait-stated memory bus between the CPU instruction-fetch and data ports.
//  Sits between the core's instr_/data_ request ports and the memory.
//  Arbitrates one transaction at a time and steers readdata/waitrequest back to the winner.
//  Flags bus hangs and protocol violations.
// PARAMETERS
//  ADDR_W          32    address width, all ports
//  DATA_W          32    data width, all ports
//  TIMEOUT_CYCLES  1024  waitrequest cycles tolerated in one grant before timeout_err is set; 0 disables
// PORTS
//  clk              in   1       clock; all logic on posedge
//  rst_n            in   1       synchronous, active-low reset
//  instr_address    in   ADDR_W  fetch address
//  instr_read       in   1       fetch request; held until instr_waitrequest=0
//  instr_readdata   out  DATA_W  fetch data; valid in the cycle instr_waitrequest=0
//  instr_waitrequest out 1       1 = fetch not yet complete
//  data_address     in   ADDR_W  data address
//  data_read        in   1       data read request
//  data_write       in   1       data write request
//  data_writedata   in   DATA_W  write data
//  data_byteenable  in   DATA_W/8  byte lanes
//  data_readdata    out  DATA_W  read data; valid in the cycle data_waitrequest=0
//  data_waitrequest out  1       1 = data access not yet complete
//  mem_address      out  ADDR_W  to memory
//  mem_read         out  1       to memory
//  mem_write        out  1       to memory
//  mem_writedata    out  DATA_W  to memory
//  mem_byteenable   out  DATA_W/8  to memory; all-ones for fetches
//  mem_readdata     in   DATA_W  from memory
//  mem_waitrequest  in   1       from memory; 0 = access completes this cycle
//  timeout_err      out  1       sticky; cleared only by reset
//  proto_err        out  1       sticky; set when data_read & data_write in the same cycle
// BEHAVIOUR
//  FSM (arb_state_t): IDLE, GNT_I, GNT_D.
//  Reset (rst_n=0 at posedge): state=IDLE; rr pointer=instr; both errors=0; timeout counter=0.
//  IDLE outputs: mem_read=0, mem_write=0, instr/data_waitrequest=1, readdata=0.
//  IDLE: winner is decided combinationally; the state registers it next cycle (1 cycle arbitration latency).
//  Nothing is issued to memory in IDLE.
//  GNT_x: mem_* is driven combinationally from requester x's inputs.
//    x_waitrequest=mem_waitrequest; x_readdata=mem_readdata.
//    Loser waitrequest=1; loser readdata=0.
//  Completion = GNT_x & mem_waitrequest=0.
//    Re-arbitrate in that cycle with x's request masked; go to the other grant if it is pending, else IDLE.
//    Back-to-back x->x always passes through IDLE.
//  Requester deasserting its request while granted (protocol violation):
//    mem_read/mem_write follow the input to 0; FSM stays in GNT_x until completion.
//  data_read & data_write both 1: treated as a write; proto_err set next cycle.
//  Timeout: counter increments every GNT cycle with mem_waitrequest=1 and clears on completion or in IDLE.
//    At count==TIMEOUT_CYCLES, timeout_err is set; the grant is NOT aborted. The counter saturates.
//  Reset mid-transaction: next cycle is IDLE with mem_read=mem_write=0. The memory access is abandoned.
// CONFIGURATION
//  MIPS_MEM_ARB_RR_EN defined: round-robin; the rr pointer flips to the non-winner on each completion.
//    Simultaneous requests go to the requester the pointer names.
//  MIPS_MEM_ARB_RR_EN undefined: fixed priority, data > instr; the rr pointer is absent.
// STRUCTURE
//  Package mips_cpu_arb_pkg: arb_state_t enum {IDLE,GNT_I,GNT_D}; req_id_t enum {REQ_I,REQ_D}.
//    Also holds the default ADDR_W/DATA_W localparams.
//  Sub-module mips_cpu_arb_timeout: saturating counter with clear, count-enable and sticky flag.
// TESTING
//  1. instr_read only, addr 0xBFC00000, mem_waitrequest=0:
//     GNT_I one cycle after the request; instr_readdata=mem_readdata; instr_waitrequest low for exactly 1 cycle.
//  2. instr_read and data_read rise together, RR_EN defined, pointer=instr after reset:
//     instr granted first, then data with no IDLE gap. Undefined: data first.
//  3. data_write 0x12345678 to 0x00001000, byteenable 4'b0011, mem_waitrequest high 3 cycles:
//     mem_write=1 for 4 cycles; data_waitrequest=0 on the 4th.
//  4. mem_waitrequest stuck high, TIMEOUT_CYCLES=8: timeout_err rises after 8 waited cycles and stays high.
//  5. data_read=data_write=1: mem_write=1, mem_read=0; proto_err=1 next cycle.
//  6. rst_n=0 during GNT_D with wait pending: next cycle state=IDLE, mem_read=mem_write=0, errors=0.

Source files
------------

// File: rtl/mips_cpu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_cpu_arb_pkg
// Purpose : Shared types and default widths for the CPU memory arbiter.
//           arb_state_t : arbiter FSM states (IDLE, GNT_I, GNT_D)
//           req_id_t    : requester identity (instruction fetch / data)
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mips_cpu_arb_pkg;

  localparam int c_ADDR_W = 32;
  localparam int c_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage : mips_cpu_arb_pkg
`default_nettype wire

// File: rtl/mips_cpu_arb_timeout.sv
`default_nettype none
// ============================================================================
// Module  : mips_cpu_arb_timeout
// Purpose : Saturating wait-cycle counter with synchronous clear and a sticky
//           flag that rises in the same cycle the count reaches MAX_COUNT.
//           MAX_COUNT = 0 removes the counter and ties the flag low.
// Ports   : clk     - clock
//           rst_n   - synchronous active-low reset (clears count and flag)
//           i_clr   - clear count (flag is unaffected)
//           i_en    - count one waited cycle
//           o_flag  - sticky timeout flag
// Rev     : 1.0  initial release
// ============================================================================
module mips_cpu_arb_timeout #(
  parameter int MAX_COUNT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_flag
);

  generate
    if (MAX_COUNT == 0) begin : g_disabled
      assign o_flag = 1'b0;
    end else begin : g_enabled
      localparam int c_CNT_W = $clog2(MAX_COUNT + 1);
      localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_COUNT);

      logic [c_CNT_W-1:0] r_count;
      logic               r_flag;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_count <= '0;
          r_flag  <= 1'b0;
        end else begin
          if (i_clr) begin
            r_count <= '0;
          end else if (i_en && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
            // Flag becomes visible together with count == MAX.
            if (r_count == (c_MAX - 1'b1)) begin
              r_flag <= 1'b1;
            end
          end
        end
      end

      assign o_flag = r_flag;
    end
  endgenerate

endmodule : mips_cpu_arb_timeout
`default_nettype wire

// File: rtl/mips_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mips_cpu_mem_arbiter
// Purpose : Shares one wait-stated memory bus between the CPU fetch (instr_*)
//           and data (data_*) ports, one transaction at a time. Flags bus
//           hangs (timeout_err) and simultaneous read+write (proto_err).
// Config  : MIPS_MEM_ARB_RR_EN defined   -> round-robin arbitration
//           MIPS_MEM_ARB_RR_EN undefined -> fixed priority, data over instr
// Ports   : clk, rst_n (sync, active-low)
//           instr_address/read        -> fetch request
//           instr_readdata/waitrequest <- fetch response
//           data_address/read/write/writedata/byteenable -> data request
//           data_readdata/waitrequest <- data response
//           mem_address/read/write/writedata/byteenable  -> memory
//           mem_readdata/waitrequest  <- memory
//           timeout_err, proto_err    -> sticky error flags
// Rev     : 1.0  initial release
// ============================================================================
module mips_cpu_mem_arbiter
  import mips_cpu_arb_pkg::*;
#(
  parameter int ADDR_W         = c_ADDR_W,
  parameter int DATA_W         = c_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   instr_address,
  input  logic                instr_read,
  output logic [DATA_W-1:0]   instr_readdata,
  output logic                instr_waitrequest,
  input  logic [ADDR_W-1:0]   data_address,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [DATA_W-1:0]   data_writedata,
  input  logic [DATA_W/8-1:0] data_byteenable,
  output logic [DATA_W-1:0]   data_readdata,
  output logic                data_waitrequest,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                mem_waitrequest,
  output logic                timeout_err,
  output logic                proto_err
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  req_id_t    w_winner;
  logic       w_instr_req;
  logic       w_data_req;
  logic       w_complete;
  logic       r_proto_err;

  assign w_instr_req = instr_read;
  assign w_data_req  = data_read | data_write;
  assign w_complete  = (r_state != IDLE) && !mem_waitrequest;

  // Winner used only when leaving IDLE; on completion the other requester
  // is the only candidate, so no priority decision is needed there.
`ifdef MIPS_MEM_ARB_RR_EN
  req_id_t r_rr_ptr;

  always_comb begin
    w_winner = REQ_I;
    if (w_instr_req && w_data_req) begin
      w_winner = r_rr_ptr;
    end else if (w_data_req) begin
      w_winner = REQ_D;
    end
  end

  // Pointer names the requester that did not just finish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= REQ_I;
    end else if (w_complete) begin
      r_rr_ptr <= (r_state == GNT_I) ? REQ_D : REQ_I;
    end
  end
`else
  assign w_winner = w_data_req ? REQ_D : REQ_I;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    mem_address       = '0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_writedata     = '0;
    mem_byteenable    = '0;
    instr_readdata    = '0;
    instr_waitrequest = 1'b1;
    data_readdata     = '0;
    data_waitrequest  = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_instr_req || w_data_req) begin
          w_state_next = (w_winner == REQ_D) ? GNT_D : GNT_I;
        end
      end
      GNT_I: begin
        mem_address       = instr_address;
        mem_read          = instr_read;
        mem_byteenable    = '1;
        instr_readdata    = mem_readdata;
        instr_waitrequest = mem_waitrequest;
        if (w_complete) begin
          w_state_next = w_data_req ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        mem_address      = data_address;
        // A read+write collision is executed as a write.
        mem_read         = data_read & ~data_write;
        mem_write        = data_write;
        mem_writedata    = data_writedata;
        mem_byteenable   = data_byteenable;
        data_readdata    = mem_readdata;
        data_waitrequest = mem_waitrequest;
        if (w_complete) begin
          w_state_next = w_instr_req ? GNT_I : IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_proto_err <= 1'b0;
    end else if (data_read && data_write) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;

  mips_cpu_arb_timeout #(
    .MAX_COUNT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  ((r_state == IDLE) || w_complete),
    .i_en   ((r_state != IDLE) && mem_waitrequest),
    .o_flag (timeout_err)
  );

endmodule : mips_cpu_mem_arbiter
`default_nettype wire
